// File: rtl/money_pkg.sv
// Shared money constants, FSM state codes and the saturation-ceiling helper
// for the vending machine money datapath.
package money_pkg;

   localparam int unsigned MONEY_W   = 11;
   localparam int unsigned MAX_MONEY = 2047;

   typedef logic [MONEY_W-1:0] money_t;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ACCUM   = 3'd1;
   localparam logic [2:0] VEND    = 3'd2;
   localparam logic [2:0] CHANGE  = 3'd3;
   localparam logic [2:0] COLLECT = 3'd4;

   localparam logic [MONEY_W:0] MAX_MONEY_EXT = (MONEY_W + 1)'(MAX_MONEY);

   // Sum is formed one bit wider so the comparison can never wrap.
   function automatic logic fits(input money_t a, input money_t b);
      logic [MONEY_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum <= MAX_MONEY_EXT;
   endfunction

endpackage

// File: rtl/credit_accum.sv
// Customer credit register: add (with ceiling check), subtract and clear,
// driven by control strobes from the money sequencer FSM.
module credit_accum
   import money_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               add,
   input  logic [MONEY_W-1:0] add_value,
   input  logic               sub,
   input  logic [MONEY_W-1:0] sub_value,
   input  logic               clr,
   output logic               can_add,
   output logic [MONEY_W-1:0] credit
);

   logic [MONEY_W-1:0] credit_q;

   assign can_add = fits(credit_q, add_value);
   assign credit  = credit_q;

   // Clear wins over subtract, subtract over add; the FSM never asserts two at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_q <= '0;
      end else if (clr) begin
         credit_q <= '0;
      end else if (sub) begin
         credit_q <= credit_q - sub_value;
      end else if (add && can_add) begin
         credit_q <= credit_q + add_value;
      end
   end

endmodule

// File: rtl/money_sequencer.sv
// Money sequencer: arbitrates coins, purchases, cancels and owner collection
// over the credit and bank registers. Define AUDIT_COUNT_EN for audit counters.
module money_sequencer
   import money_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic               coin_valid,
   input  logic [MONEY_W-1:0] coin_value,
   input  logic               sel_valid,
   input  logic [MONEY_W-1:0] price,
   input  logic               cancel,
   input  logic               collect_req,
   output logic [MONEY_W-1:0] credit,
   output logic [MONEY_W-1:0] machine_money,
   output logic               vend,
   output logic               change_valid,
   output logic [MONEY_W-1:0] change_amount,
   output logic               owner_valid,
   output logic [MONEY_W-1:0] owner_money,
   output logic               redlight,
   output logic               coin_reject,
   output logic               busy
`ifdef AUDIT_COUNT_EN
   ,
   output logic [15:0]        vend_count,
   output logic [MONEY_W+7:0] collected_total
`endif
);

   logic [2:0]         state_q, state_d;
   logic [MONEY_W-1:0] price_q, price_d;
   logic [MONEY_W-1:0] bank_q;
   logic               pending_q, pending_d;
   logic               vend_q, change_valid_q, owner_valid_q, redlight_q, coin_reject_q;
   logic [MONEY_W-1:0] change_amount_q, owner_money_q;

   logic coin_take, coin_rej_d, credit_sub, credit_clr, can_add;
   logic owner_req, sel_ok;

   assign owner_req = collect_req & mode;
   assign sel_ok    = sel_valid && (credit >= price) && fits(bank_q, price);

   credit_accum u_credit (
      .clk       (clk),
      .rst       (rst),
      .add       (coin_take),
      .add_value (coin_value),
      .sub       (credit_sub),
      .sub_value (price_q),
      .clr       (credit_clr),
      .can_add   (can_add),
      .credit    (credit)
   );

   always_comb begin
      state_d    = state_q;
      price_d    = price_q;
      pending_d  = pending_q;
      coin_take  = 1'b0;
      credit_sub = 1'b0;
      credit_clr = 1'b0;
      // Any coin not explicitly taken below is refused.
      coin_rej_d = coin_valid;
      case (state_q)
         IDLE: begin
            if (pending_q || owner_req) begin
               state_d   = COLLECT;
               pending_d = 1'b0;
            end else if (coin_valid && !mode && can_add) begin
               coin_take  = 1'b1;
               coin_rej_d = 1'b0;
               state_d    = (coin_value != '0) ? ACCUM : IDLE;
            end
         end
         ACCUM: begin
            if (cancel || owner_req) begin
               // Refund first; an owner request is replayed from IDLE afterwards.
               state_d   = CHANGE;
               pending_d = owner_req;
            end else if (sel_ok) begin
               state_d = VEND;
               price_d = price;
            end else if (coin_valid && !mode && can_add) begin
               coin_take  = 1'b1;
               coin_rej_d = 1'b0;
            end
         end
         VEND: begin
            credit_sub = 1'b1;
            state_d    = CHANGE;
         end
         CHANGE: begin
            credit_clr = 1'b1;
            state_d    = IDLE;
         end
         COLLECT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         price_q         <= '0;
         bank_q          <= '0;
         pending_q       <= 1'b0;
         vend_q          <= 1'b0;
         change_valid_q  <= 1'b0;
         change_amount_q <= '0;
         owner_valid_q   <= 1'b0;
         owner_money_q   <= '0;
         redlight_q      <= 1'b0;
         coin_reject_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         price_q        <= price_d;
         pending_q      <= pending_d;
         coin_reject_q  <= coin_rej_d;
         vend_q         <= (state_q == VEND);
         change_valid_q <= (state_q == CHANGE);
         owner_valid_q  <= (state_q == COLLECT);
         if (state_q == VEND) begin
            bank_q <= bank_q + price_q;
         end
         if (state_q == CHANGE) begin
            change_amount_q <= credit;
         end
         if (state_q == COLLECT) begin
            owner_money_q <= bank_q;
            redlight_q    <= (bank_q == '0);
            bank_q        <= '0;
         end
      end
   end

`ifdef AUDIT_COUNT_EN
   logic [15:0]        vend_count_q;
   logic [MONEY_W+7:0] total_q;
   logic [MONEY_W+8:0] total_sum;

   assign total_sum = {1'b0, total_q} + {9'b0, bank_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vend_count_q <= '0;
         total_q      <= '0;
      end else begin
         if (state_q == VEND) begin
            vend_count_q <= vend_count_q + 16'd1;
         end
         if (state_q == COLLECT) begin
            total_q <= total_sum[MONEY_W+8] ? '1 : total_sum[MONEY_W+7:0];
         end
      end
   end

   assign vend_count      = vend_count_q;
   assign collected_total = total_q;
`endif

   assign machine_money = bank_q;
   assign vend          = vend_q;
   assign change_valid  = change_valid_q;
   assign change_amount = change_amount_q;
   assign owner_valid   = owner_valid_q;
   assign owner_money   = owner_money_q;
   assign redlight      = redlight_q;
   assign coin_reject   = coin_reject_q;
   assign busy          = (state_q != IDLE) && (state_q != ACCUM);

endmodule

// File: tb/tb_money_sequencer.sv
// Self-checking bench for money_sequencer: directed scenarios then random
// transactions compared against a transaction-level money model.
module tb_money_sequencer;
   import money_pkg::*;

   logic               clk = 1'b0;
   logic               rst, mode, coin_valid, sel_valid, cancel, collect_req;
   logic [MONEY_W-1:0] coin_value, price;
   logic [MONEY_W-1:0] credit, machine_money, change_amount, owner_money;
   logic               vend, change_valid, owner_valid, redlight, coin_reject, busy;
`ifdef AUDIT_COUNT_EN
   logic [15:0]        vend_count;
   logic [MONEY_W+7:0] collected_total;
`endif

   always #5 clk = ~clk;

   money_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .mode          (mode),
      .coin_valid    (coin_valid),
      .coin_value    (coin_value),
      .sel_valid     (sel_valid),
      .price         (price),
      .cancel        (cancel),
      .collect_req   (collect_req),
      .credit        (credit),
      .machine_money (machine_money),
      .vend          (vend),
      .change_valid  (change_valid),
      .change_amount (change_amount),
      .owner_valid   (owner_valid),
      .owner_money   (owner_money),
      .redlight      (redlight),
      .coin_reject   (coin_reject),
      .busy          (busy)
`ifdef AUDIT_COUNT_EN
      ,
      .vend_count      (vend_count),
      .collected_total (collected_total)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: money held by customer and bank, last payouts.
   int m_credit, m_bank, m_change, m_owner, m_vends, m_total;
   logic m_red;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_credit = 0; m_bank = 0; m_change = 0; m_owner = 0;
      m_vends = 0; m_total = 0; m_red = 1'b0;
   endtask

   task automatic model_collect();
      m_owner = m_bank;
      m_red   = (m_bank == 0);
      m_total = (m_total + m_bank > (1 << (MONEY_W + 8)) - 1) ? (1 << (MONEY_W + 8)) - 1
                                                              : m_total + m_bank;
      m_bank  = 0;
   endtask

   task automatic check_levels(input string tag);
      check({tag, "_credit"}, 32'(credit), 32'(m_credit));
      check({tag, "_bank"}, 32'(machine_money), 32'(m_bank));
      check({tag, "_change_amt"}, 32'(change_amount), 32'(m_change));
      check({tag, "_owner_amt"}, 32'(owner_money), 32'(m_owner));
      check({tag, "_redlight"}, 32'(redlight), 32'(m_red));
      check({tag, "_busy"}, 32'(busy), 32'(0));
`ifdef AUDIT_COUNT_EN
      check({tag, "_vend_count"}, 32'(vend_count), 32'(m_vends & 16'hffff));
      check({tag, "_total"}, 32'(collected_total), 32'(m_total));
`endif
   endtask

   // One strobe cycle, then six sampled cycles; pulse vectors are indexed by
   // the number of rising edges since the strobe was captured.
   task automatic apply(input string tag, input bit cv, input int cval, input bit sv,
                        input int pr, input bit cn, input bit cr, input bit md);
      logic [6:1] ev, ec, eo, er, eb, ov, oc, oo, orj, ob;
      bit idle, taken;
      ev = '0; ec = '0; eo = '0; er = '0; eb = '0;
      ov = '0; oc = '0; oo = '0; orj = '0; ob = '0;
      idle  = (m_credit == 0);
      taken = 1'b0;
      if (cr && md && idle) begin
         eo[2] = 1'b1; eb[1] = 1'b1;
         model_collect();
      end else if (!idle && (cn || (cr && md))) begin
         ec[2] = 1'b1; eb[1] = 1'b1;
         m_change = m_credit; m_credit = 0;
         if (cr && md) begin
            eo[4] = 1'b1; eb[3] = 1'b1;
            model_collect();
         end
      end else if (!idle && sv && m_credit >= pr && m_bank + pr <= int'(MAX_MONEY)) begin
         ev[2] = 1'b1; ec[3] = 1'b1; eb[1] = 1'b1; eb[2] = 1'b1;
         m_bank += pr; m_change = m_credit - pr; m_credit = 0; m_vends++;
      end else if (cv && !md && m_credit + cval <= int'(MAX_MONEY)) begin
         m_credit += cval; taken = 1'b1;
      end
      if (cv && !taken) er[1] = 1'b1;

      @(negedge clk);
      mode = md; coin_valid = cv; coin_value = cval[MONEY_W-1:0];
      sel_valid = sv; price = pr[MONEY_W-1:0]; cancel = cn; collect_req = cr;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         ov[k] = vend; oc[k] = change_valid; oo[k] = owner_valid;
         orj[k] = coin_reject; ob[k] = busy;
         coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; collect_req = 1'b0;
      end
      mode = 1'b0;
      check({tag, "_vend"}, 32'(ov), 32'(ev));
      check({tag, "_change_valid"}, 32'(oc), 32'(ec));
      check({tag, "_owner_valid"}, 32'(oo), 32'(eo));
      check({tag, "_coin_reject"}, 32'(orj), 32'(er));
      check({tag, "_busy_trace"}, 32'(ob), 32'(eb));
      check_levels(tag);
   endtask

   initial begin
      logic [6:1] rv, rc;
      int op, cval, pr;
      model_reset();
      rst = 1'b1; mode = 1'b0; coin_valid = 1'b0; coin_value = '0;
      sel_valid = 1'b0; price = '0; cancel = 1'b0; collect_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_vend", 32'(vend), 32'(0));
      check("reset_change_valid", 32'(change_valid), 32'(0));
      check("reset_owner_valid", 32'(owner_valid), 32'(0));
      check("reset_coin_reject", 32'(coin_reject), 32'(0));
      check_levels("reset");
      rst = 1'b0;

      // Empty-bank collection lights the red light.
      apply("collect_empty", 0, 0, 0, 0, 0, 1, 1);
      check("collect_empty_red", 32'(redlight), 32'(1));

      // Coins 5,10,20 then price 25: vend, bank 25, change 10.
      apply("coin5", 1, 5, 0, 0, 0, 0, 0);
      apply("coin10", 1, 10, 0, 0, 0, 0, 0);
      apply("coin20", 1, 20, 0, 0, 0, 0, 0);
      check("plan1_credit35", 32'(credit), 32'(35));
      apply("sel25", 0, 0, 1, 25, 0, 0, 0);
      check("plan1_bank25", 32'(machine_money), 32'(25));
      check("plan1_change10", 32'(change_amount), 32'(10));
      apply("collect25", 0, 0, 0, 0, 0, 1, 1);
      check("collect25_red_off", 32'(redlight), 32'(0));

      // Saturation: credit 2040, coin 10 refused, cancel refunds everything.
      apply("big1000a", 1, 1000, 0, 0, 0, 0, 0);
      apply("big1000b", 1, 1000, 0, 0, 0, 0, 0);
      apply("big40", 1, 40, 0, 0, 0, 0, 0);
      apply("ovf_coin", 1, 10, 0, 0, 0, 0, 0);
      check("ovf_credit_hold", 32'(credit), 32'(2040));
      apply("cancel2040", 0, 0, 0, 0, 1, 0, 0);
      check("cancel2040_amt", 32'(change_amount), 32'(2040));

      // Vend 30 then collect it; then insufficient credit sel ignored.
      apply("coin30", 1, 30, 0, 0, 0, 0, 0);
      apply("sel30", 0, 0, 1, 30, 0, 0, 0);
      apply("collect30", 0, 0, 0, 0, 0, 1, 1);
      check("collect30_amt", 32'(owner_money), 32'(30));
      apply("coin7", 1, 7, 0, 0, 0, 0, 0);
      apply("sel_short", 0, 0, 1, 8, 0, 0, 0);
      apply("cancel7", 0, 0, 0, 0, 1, 0, 0);

      // Owner request with credit pending: refund first, then collection.
      apply("coin50", 1, 50, 0, 0, 0, 0, 0);
      apply("sel20", 0, 0, 1, 20, 0, 0, 0);
      apply("coin15", 1, 15, 0, 0, 0, 0, 0);
      apply("collect_accum", 0, 0, 0, 0, 0, 1, 1);
      check("collect_accum_chg", 32'(change_amount), 32'(15));
      check("collect_accum_own", 32'(owner_money), 32'(20));

      // cancel + sel + coin together: refund wins, coin refused.
      apply("coin40", 1, 40, 0, 0, 0, 0, 0);
      apply("triple", 1, 5, 1, 10, 1, 0, 0);
      check("triple_amt", 32'(change_amount), 32'(40));

      // Mode-1 coin refused.
      apply("owner_coin", 1, 5, 0, 0, 0, 0, 1);

      // Reset during the VEND cycle: nothing completes, everything cleared.
      apply("coin60", 1, 60, 0, 0, 0, 0, 0);
      @(negedge clk);
      sel_valid = 1'b1; price = 11'd20;
      @(negedge clk);
      sel_valid = 1'b0;
      check("pre_rst_busy", 32'(busy), 32'(1));
      rst = 1'b1;
      rv = '0; rc = '0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         rv[k] = vend; rc[k] = change_valid;
         if (k == 1) rst = 1'b0;
      end
      model_reset();
      check("rst_vend_trace", 32'(rv), 32'(0));
      check("rst_change_trace", 32'(rc), 32'(0));
      check_levels("rst_mid_vend");

      // Random transactions against the model.
      for (int i = 0; i < 200; i++) begin
         op = int'($urandom_range(0, 9));
         cval = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1000, 2047))
                                            : int'($urandom_range(1, 100));
         pr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1500, 2047))
                                          : int'($urandom_range(0, 150));
         case (op)
            0, 1, 2, 3: apply("rnd_coin", 1, cval, 0, 0, 0, 0, ($urandom_range(0, 7) == 0));
            4, 5:       apply("rnd_sel", 0, 0, 1, pr, 0, 0, 0);
            6:          apply("rnd_cancel", 0, 0, 0, 0, 1, 0, 0);
            7:          apply("rnd_collect", 0, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
            8:          apply("rnd_combo", 1'($urandom_range(0, 1)), cval, 1'($urandom_range(0, 1)),
                              pr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
            default:    apply("rnd_collect1", 0, 0, 0, 0, 0, 1, 1);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
